// File: rtl/reg_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter_if
// Description : Bundle between N requesters and the shared-register write
//               arbiter.
//               Requester side (master) drives req, lock and wdata.
//               Arbiter side (slave) returns ack, q, q_valid, owner, locked
//               and lock_expired.
//               Ports: req[N], lock[N], wdata[N*W] (lane i = wdata[i*W +: W]),
//               ack[N], q[W], q_valid, owner[clog2(N)], locked, lock_expired.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_write_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int c_ow = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*W-1:0]  wdata;
  logic [N-1:0]    ack;
  logic [W-1:0]    q;
  logic            q_valid;
  logic [c_ow-1:0] owner;
  logic            locked;
  logic            lock_expired;

  modport master (
    output req, lock, wdata,
    input  ack, q, q_valid, owner, locked, lock_expired
  );

  modport slave (
    input  req, lock, wdata,
    output ack, q, q_valid, owner, locked, lock_expired
  );
endinterface
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter
// Description : Round-robin arbiter owning the single write port of a shared
//               W-bit register. One write lands per clock. A requester may
//               lock the register for an atomic multi-write sequence; a
//               watchdog forces release after MAX_LOCK locked cycles without
//               an owner write.
//               Ports: clk    - rising-edge clock
//                      reset  - asynchronous active-high reset
//                      bus    - reg_write_arbiter_if slave modport
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_LOCK = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  reg_write_arbiter_if.slave bus
);

  localparam int c_pw = (N > 1) ? $clog2(N) : 1;
  localparam int c_cw = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

  localparam logic [c_pw-1:0] c_last_idx = c_pw'(N - 1);
  localparam logic [c_cw-1:0] c_cnt_max  = c_cw'(MAX_LOCK - 1);

  localparam logic [0:0] c_idle   = 1'b0;
  localparam logic [0:0] c_locked = 1'b1;

  logic [0:0]      r_state;
  logic [c_pw-1:0] r_ptr;
  logic [c_cw-1:0] r_cnt;
  logic [W-1:0]    r_q;
  logic            r_q_valid;
  logic [c_pw-1:0] r_owner;
  logic            r_lock_expired;

  logic [0:0]      w_state_nxt;
  logic [c_pw-1:0] w_ptr_nxt;
  logic [c_cw-1:0] w_cnt_nxt;
  logic            w_we;
  logic [c_pw-1:0] w_sel;
  logic            w_expire;
  logic [W-1:0]    w_wdata_sel;
  logic            w_grant_vld;
  logic [c_pw-1:0] w_grant;
  logic [N-1:0]    w_ack;

  // Index increment with wrap at N; N need not be a power of two.
  function automatic logic [c_pw-1:0] f_inc(input logic [c_pw-1:0] v);
    return (v == c_last_idx) ? '0 : v + c_pw'(1);
  endfunction

  // Round-robin scan starting at r_ptr; first pending requester wins.
  always_comb begin
    logic [c_pw-1:0] v_idx;
    w_grant_vld = 1'b0;
    w_grant     = '0;
    v_idx       = r_ptr;
    for (int k = 0; k < N; k++) begin
      if (!w_grant_vld && bus.req[v_idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = v_idx;
      end
      v_idx = f_inc(v_idx);
    end
  end

  // Write-data lane select for the accepted writer.
  always_comb begin
    w_wdata_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (w_sel == c_pw'(i)) begin
        w_wdata_sel = bus.wdata[i*W +: W];
      end
    end
  end

  // State register (plus the datapath that moves with it).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= c_idle;
      r_ptr          <= '0;
      r_cnt          <= '0;
      r_q            <= '0;
      r_q_valid      <= 1'b0;
      r_owner        <= '0;
      r_lock_expired <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_ptr          <= w_ptr_nxt;
      r_cnt          <= w_cnt_nxt;
      r_q_valid      <= w_we;
      r_lock_expired <= w_expire;
      if (w_we) begin
        r_q     <= w_wdata_sel;
        r_owner <= w_sel;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_we        = 1'b0;
    w_sel       = r_owner;
    w_expire    = 1'b0;
    case (r_state)
      c_idle: begin
        if (w_grant_vld) begin
          w_we  = 1'b1;
          w_sel = w_grant;
          if (bus.lock[w_grant]) begin
            // Pointer stays put on lock entry; it moves past the holder on release.
            w_state_nxt = c_locked;
            w_cnt_nxt   = '0;
          end else begin
            w_ptr_nxt = f_inc(w_grant);
          end
        end
      end
      c_locked: begin
        if (bus.req[r_owner]) begin
          // Owner write beats the watchdog even in its final cycle.
          w_we      = 1'b1;
          w_cnt_nxt = '0;
          if (!bus.lock[r_owner]) begin
            w_state_nxt = c_idle;
            w_ptr_nxt   = f_inc(r_owner);
          end
        end else if (!bus.lock[r_owner]) begin
          // Abandon: owner released without writing.
          w_state_nxt = c_idle;
          w_ptr_nxt   = f_inc(r_owner);
        end else if (r_cnt == c_cnt_max) begin
          w_state_nxt = c_idle;
          w_ptr_nxt   = f_inc(r_owner);
          w_expire    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_cw'(1);
        end
      end
      default: begin
        w_state_nxt = c_idle;
      end
    endcase
  end

  // Output logic. ack is forced low while reset is asserted.
  always_comb begin
    w_ack = '0;
    if (!reset) begin
      if (r_state == c_idle) begin
        if (w_grant_vld) begin
          w_ack[w_grant] = 1'b1;
        end
      end else begin
        w_ack[r_owner] = bus.req[r_owner];
      end
    end
  end

  assign bus.ack          = w_ack;
  assign bus.q            = r_q;
  assign bus.q_valid      = r_q_valid;
  assign bus.owner        = r_owner;
  assign bus.locked       = (r_state == c_locked);
  assign bus.lock_expired = r_lock_expired;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_write_arbiter
// Description : Self-checking bench for reg_write_arbiter. Two instances
//               (N=4/MAX_LOCK=16 and N=3/MAX_LOCK=4) are compared every cycle
//               against a behavioural model, with directed sequences followed
//               by randomized handshake-compliant traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

  logic clk;
  logic reset;

  logic [3:0]  r4, l4;
  logic [31:0] wd4;
  logic [2:0]  r3, l3;
  logic [23:0] wd3;

  int checks = 0;
  int errors = 0;

  reg_write_arbiter_if #(.N(4), .W(8)) if4 ();
  reg_write_arbiter_if #(.N(3), .W(8)) if3 ();

  assign if4.req   = r4;
  assign if4.lock  = l4;
  assign if4.wdata = wd4;
  assign if3.req   = r3;
  assign if3.lock  = l3;
  assign if3.wdata = wd3;

  reg_write_arbiter #(.N(4), .W(8), .MAX_LOCK(16)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4)
  );

  reg_write_arbiter #(.N(3), .W(8), .MAX_LOCK(4)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0] q;
    bit         qv;
    int         owner;
    bit         locked;
    bit         expired;
    int         ptr;
    int         idle_cycles; // locked cycles since the last owner write
  } mstate_t;

  mstate_t m4, m3;
  logic [15:0] acked4, acked3;

  function automatic mstate_t m_reset();
    mstate_t s;
    s.q = 8'h00; s.qv = 0; s.owner = 0; s.locked = 0; s.expired = 0;
    s.ptr = 0; s.idle_cycles = 0;
    return s;
  endfunction

  function automatic int m_grant(mstate_t s, int n, logic [15:0] req);
    for (int k = 0; k < n; k++) begin
      if (req[(s.ptr + k) % n]) return (s.ptr + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [15:0] m_ack(mstate_t s, int n, logic [15:0] req, logic rst);
    int g;
    if (rst) return 16'h0;
    if (s.locked) return req[s.owner] ? (16'h1 << s.owner) : 16'h0;
    g = m_grant(s, n, req);
    return (g < 0) ? 16'h0 : (16'h1 << g);
  endfunction

  function automatic mstate_t m_step(mstate_t s, int n, int maxl, logic [15:0] req,
                                     logic [15:0] lock, logic [127:0] wd, logic rst);
    mstate_t t;
    int g, o;
    if (rst) return m_reset();
    t = s; t.qv = 0; t.expired = 0;
    if (!s.locked) begin
      g = m_grant(s, n, req);
      if (g >= 0) begin
        t.q = wd[g*8 +: 8]; t.owner = g; t.qv = 1;
        if (lock[g]) begin t.locked = 1; t.idle_cycles = 0; end
        else t.ptr = (g + 1) % n;
      end
    end else begin
      o = s.owner;
      if (req[o]) begin
        t.q = wd[o*8 +: 8]; t.qv = 1; t.idle_cycles = 0;
        if (!lock[o]) begin t.locked = 0; t.ptr = (o + 1) % n; end
      end else if (!lock[o]) begin
        t.locked = 0; t.ptr = (o + 1) % n;
      end else if (s.idle_cycles + 1 >= maxl) begin
        t.locked = 0; t.expired = 1; t.ptr = (o + 1) % n;
      end else begin
        t.idle_cycles = s.idle_cycles + 1;
      end
    end
    return t;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [15:0] a4, a3;
    a4 = m_ack(m4, 4, {12'h0, r4}, reset);
    a3 = m_ack(m3, 3, {13'h0, r3}, reset);
    check("n4.ack",    32'(if4.ack),          32'(a4));
    check("n4.q",      32'(if4.q),            32'(m4.q));
    check("n4.qv",     32'(if4.q_valid),      32'(m4.qv));
    check("n4.owner",  32'(if4.owner),        32'(m4.owner));
    check("n4.locked", 32'(if4.locked),       32'(m4.locked));
    check("n4.exp",    32'(if4.lock_expired), 32'(m4.expired));
    check("n3.ack",    32'(if3.ack),          32'(a3));
    check("n3.q",      32'(if3.q),            32'(m3.q));
    check("n3.qv",     32'(if3.q_valid),      32'(m3.qv));
    check("n3.owner",  32'(if3.owner),        32'(m3.owner));
    check("n3.locked", 32'(if3.locked),       32'(m3.locked));
    check("n3.exp",    32'(if3.lock_expired), 32'(m3.expired));
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    acked4 = m_ack(m4, 4, {12'h0, r4}, reset) & {12'h0, r4};
    acked3 = m_ack(m3, 3, {13'h0, r3}, reset) & {13'h0, r3};
    m4 = m_step(m4, 4, 16, {12'h0, r4}, {12'h0, l4}, {96'h0, wd4}, reset);
    m3 = m_step(m3, 3, 4,  {13'h0, r3}, {13'h0, l3}, {104'h0, wd3}, reset);
    #1;
  endtask

  // Requesters that were idle or just acked pick new traffic; others hold.
  task automatic gen(input int n, input mstate_t s, input logic [15:0] acked,
                     inout logic [15:0] r, inout logic [15:0] l, inout logic [127:0] wd);
    for (int i = 0; i < n; i++) begin
      if (!r[i] || acked[i]) begin
        if (s.locked && s.owner == i) begin
          r[i] = ($urandom % 8) == 0;
          l[i] = ($urandom % 16) != 0;
        end else begin
          r[i] = ($urandom % 3) != 0;
          l[i] = ($urandom % 6) == 0;
        end
        wd[i*8 +: 8] = 8'($urandom);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0]  tr, tl;
    logic [127:0] twd;
    reset = 1'b1;
    r4 = '0; l4 = '0; wd4 = '0;
    r3 = '0; l3 = '0; wd3 = '0;
    m4 = m_reset(); m3 = m_reset();
    acked4 = '0; acked3 = '0;
    @(posedge clk); #1;
    tick();
    check("rst.q", 32'(if4.q), 32'h0);
    check("rst.ack", 32'(if4.ack), 32'h0);
    reset = 1'b0;

    // Single write, plus N=3 wrap setup (requester 2 writes first).
    r4 = 4'b0001; wd4[7:0] = 8'hA5;
    r3 = 3'b100;  wd3[23:16] = 8'h5C;
    #1 check("t1.ack", 32'(if4.ack), 32'h1);
    tick();
    r4 = 4'b0000;
    r3 = 3'b111; wd3 = 24'h030201;
    #1 check("n3.wrap.ack", 32'(if3.ack), 32'h1);
    check("t1.q", 32'(if4.q), 32'hA5);
    tick();
    tick();
    check("t1.qv0", 32'(if4.q_valid), 32'h0);

    // All four requesting, fresh data every cycle.
    r4 = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      wd4 = {8'(c*4+3), 8'(c*4+2), 8'(c*4+1), 8'(c*4)} ^ 32'h40404040;
      tick();
    end
    r4 = 4'b0000;
    tick();

    // Requester 2 locked sequence while others wait.
    r4 = 4'b0100; l4 = 4'b0100; wd4 = 32'h00110000;
    tick();
    r4 = 4'b1111; wd4 = 32'h77226655;
    tick();
    wd4[23:16] = 8'h33;
    tick();
    check("t3.locked", 32'(if4.locked), 32'h1);
    wd4[23:16] = 8'h44; l4 = 4'b0000;
    tick();
    check("t3.unlocked", 32'(if4.locked), 32'h0);
    r4 = 4'b1011;
    #1 check("t3.next", 32'(if4.ack), 32'h8);
    tick();

    // Watchdog: requester 1 locks then goes quiet holding lock.
    r4 = 4'b0010; l4 = 4'b0010; wd4[15:8] = 8'hB1;
    tick();
    r4 = 4'b0100; l4 = 4'b0010; wd4[23:16] = 8'hC2;
    for (int c = 0; c < 15; c++) tick();
    check("wd.pre.locked", 32'(if4.locked), 32'h1);
    check("wd.pre.exp", 32'(if4.lock_expired), 32'h0);
    tick();
    check("wd.exp", 32'(if4.lock_expired), 32'h1);
    check("wd.locked", 32'(if4.locked), 32'h0);
    check("wd.next", 32'(if4.ack), 32'h4);
    tick();
    check("wd.exp.pulse", 32'(if4.lock_expired), 32'h0);

    // Reset asserted while locked.
    r4 = 4'b1111; l4 = 4'b1111; wd4 = 32'hD4D3D2D1;
    tick();
    tick();
    check("t5.locked", 32'(if4.locked), 32'h1);
    #2 reset = 1'b1;
    #1;
    m4 = m_reset(); m3 = m_reset();
    check("t5.q", 32'(if4.q), 32'h0);
    check("t5.locked0", 32'(if4.locked), 32'h0);
    check("t5.ack0", 32'(if4.ack), 32'h0);
    check_all();
    tick();
    reset = 1'b0; l4 = 4'b0000;
    #1 check("t5.first", 32'(if4.ack), 32'h1);
    tick();

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      tr = {12'h0, r4}; tl = {12'h0, l4}; twd = {96'h0, wd4};
      gen(4, m4, acked4, tr, tl, twd);
      r4 = tr[3:0]; l4 = tl[3:0]; wd4 = twd[31:0];
      tr = {13'h0, r3}; tl = {13'h0, l3}; twd = {104'h0, wd3};
      gen(3, m3, acked3, tr, tl, twd);
      r3 = tr[2:0]; l3 = tl[2:0]; wd3 = twd[23:0];
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
